// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator: mode records,
// run-control states and the colour-bar palette.
package video_timing_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        h_sync_pol;
        logic        v_sync_pol;
    } video_timing_t;

    localparam video_timing_t VT_640X480P60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_sync_pol: 1'b0, v_sync_pol: 1'b0
    };

    localparam video_timing_t VT_800X600P60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_sync_pol: 1'b1, v_sync_pol: 1'b1
    };

    typedef enum logic {
        RUN_STOPPED = 1'b0,
        RUN_RUNNING = 1'b1
    } run_state_t;

    localparam int unsigned RGB_W = 12;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [0:7][RGB_W-1:0] COLOUR_BARS = {
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        return COLOUR_BARS[idx];
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing bundle between the generator (master) and the pixel pipeline (slave).
interface video_timing_if #(
    parameter int HW = 10,
    parameter int VW = 10
);
    logic          enable;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    logic [HW-1:0] px;
    logic [VW-1:0] py;
    logic          active;
    logic          line_start;
    logic          frame_start;
    logic          vga_hsync;
    logic          vga_vsync;
    logic          vga_de;
    logic [11:0]   pat_rgb;

    modport master (
        input  enable,
        output x, y, px, py, active, line_start, frame_start,
        output vga_hsync, vga_vsync, vga_de, pat_rgb
    );

    modport slave (
        output enable,
        input  x, y, px, py, active, line_start, frame_start,
        input  vga_hsync, vga_vsync, vga_de, pat_rgb
    );
endinterface

// File: rtl/video_timing_gen_sync_delay_line.sv
// Fixed-depth shift register that loads a caller-supplied value on reset;
// keeps sync/de/colour aligned with the pixel pipeline.
module sync_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= i_rst_val;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with frame-aligned start/stop and a
// delayed sync/de path. Optional colour-bar pattern: VIDEO_TEST_PATTERN_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE    = int'(VT_640X480P60.h_active),
    parameter int H_FP        = int'(VT_640X480P60.h_fp),
    parameter int H_SYNC      = int'(VT_640X480P60.h_sync),
    parameter int H_BP        = int'(VT_640X480P60.h_bp),
    parameter int V_ACTIVE    = int'(VT_640X480P60.v_active),
    parameter int V_FP        = int'(VT_640X480P60.v_fp),
    parameter int V_SYNC      = int'(VT_640X480P60.v_sync),
    parameter int V_BP        = int'(VT_640X480P60.v_bp),
    parameter int H_SYNC_POL  = 0,
    parameter int V_SYNC_POL  = 0,
    parameter int PIPE_DELAY  = 2,
    parameter int SCALE_SHIFT = 0
) (
    input  logic          clk_pixel,
    input  logic          rstn_pixel,
    video_timing_if.master vt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic H_ON  = 1'(H_SYNC_POL);
    localparam logic H_OFF = ~H_ON;
    localparam logic V_ON  = 1'(V_SYNC_POL);
    localparam logic V_OFF = ~V_ON;

    run_state_t    r_state;
    logic [HW-1:0] r_x;
    logic [VW-1:0] r_y;

    logic w_running;
    logic w_x_last;
    logic w_y_last;
    logic w_active;
    logic w_line_start;
    logic w_hsync0;
    logic w_vsync0;

    assign w_running = (r_state == RUN_RUNNING);
    assign w_x_last  = (r_x == H_LAST);
    assign w_y_last  = (r_y == V_LAST);

    // Stop requests are honoured only on the last pixel of a frame, so a
    // mid-frame drop of enable lets the frame finish and a re-raise cancels it.
    always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
        if (!rstn_pixel) begin
            r_state <= RUN_STOPPED;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            case (r_state)
                RUN_STOPPED: begin
                    r_x <= '0;
                    r_y <= '0;
                    if (vt.enable) begin
                        r_state <= RUN_RUNNING;
                    end
                end
                RUN_RUNNING: begin
                    if (w_x_last) begin
                        r_x <= '0;
                        if (w_y_last) begin
                            r_y <= '0;
                            if (!vt.enable) begin
                                r_state <= RUN_STOPPED;
                            end
                        end else begin
                            r_y <= r_y + 1'b1;
                        end
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_active     = w_running && (r_x < H_ACT) && (r_y < V_ACT);
    assign w_line_start = w_running && (r_x == '0);

    assign vt.x           = r_x;
    assign vt.y           = r_y;
    assign vt.px          = r_x >> SCALE_SHIFT;
    assign vt.py          = r_y >> SCALE_SHIFT;
    assign vt.active      = w_active;
    assign vt.line_start  = w_line_start;
    assign vt.frame_start = w_line_start && (r_y == '0);

    assign w_hsync0 = (w_running && (r_x >= H_SS) && (r_x < H_SE)) ? H_ON : H_OFF;
    assign w_vsync0 = (w_running && (r_y >= V_SS) && (r_y < V_SE)) ? V_ON : V_OFF;

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int            DL_W  = 3 + int'(RGB_W);
    localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

    logic [2:0]       w_bar_idx;
    logic [RGB_W-1:0] w_rgb0;
    logic [DL_W-1:0]  w_dl_d;
    logic [DL_W-1:0]  w_dl_rst;
    logic [DL_W-1:0]  w_dl_q;

    assign w_bar_idx  = 3'(r_x / BAR_W);
    assign w_rgb0     = w_active ? bar_colour(w_bar_idx) : '0;
    assign w_dl_d     = {w_hsync0, w_vsync0, w_active, w_rgb0};
    assign w_dl_rst   = {H_OFF, V_OFF, 1'b0, {RGB_W{1'b0}}};
    assign vt.pat_rgb = w_dl_q[RGB_W-1:0];
`else
    localparam int DL_W = 3;

    logic [DL_W-1:0] w_dl_d;
    logic [DL_W-1:0] w_dl_rst;
    logic [DL_W-1:0] w_dl_q;

    assign w_dl_d     = {w_hsync0, w_vsync0, w_active};
    assign w_dl_rst   = {H_OFF, V_OFF, 1'b0};
    assign vt.pat_rgb = '0;
`endif

    sync_delay_line #(
        .WIDTH (DL_W),
        .DEPTH (PIPE_DELAY)
    ) u_delay (
        .clk       (clk_pixel),
        .rst_n     (rstn_pixel),
        .i_rst_val (w_dl_rst),
        .i_d       (w_dl_d),
        .o_q       (w_dl_q)
    );

    assign vt.vga_hsync = w_dl_q[DL_W-1];
    assign vt.vga_vsync = w_dl_q[DL_W-2];
    assign vt.vga_de    = w_dl_q[DL_W-3];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen in a small 8/2/3/1 x 4/1/2/1 mode
// (H_ACTIVE 16 when VIDEO_TEST_PATTERN_EN is defined).
module tb_video_timing_gen;

`ifdef VIDEO_TEST_PATTERN_EN
    localparam int HA = 16;
`else
    localparam int HA = 8;
`endif
    localparam int HFP = 2, HS = 3, HBP = 1;
    localparam int VA  = 4, VFP = 1, VS = 2, VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int HW  = $clog2(HT);
    localparam int VW  = $clog2(VT);
    localparam int SS  = 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    video_timing_if #(.HW(HW), .VW(VW)) vif ();

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .H_SYNC_POL (0), .V_SYNC_POL (0),
        .PIPE_DELAY (2), .SCALE_SHIFT (SS)
    ) dut (
        .clk_pixel  (clk),
        .rstn_pixel (rstn),
        .vt         (vif)
    );

    typedef struct {
        int x, y, px, py;
        bit act, ls, fs, hs, vs, de;
        int pat;
    } exp_t;

    typedef struct {
        bit hs, vs, de;
        int pat;
    } stg_t;

    exp_t sb[$];
    int   fs_iv[$];
    int   ls_iv[$];
    bit   meas = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

`ifdef VIDEO_TEST_PATTERN_EN
    int bars [8] = '{'hFFF, 'hFF0, 'h0FF, 'h0F0, 'hF0F, 'hF00, 'h00F, 'h000};
`endif

    bit   m_run;
    int   m_x, m_y;
    stg_t d1, d2;

    function automatic stg_t idle_stg();
        stg_t s;
        s.hs = 1'b1; s.vs = 1'b1; s.de = 1'b0; s.pat = 0;
        return s;
    endfunction

    function automatic stg_t stage0();
        stg_t s = idle_stg();
        if (m_run) begin
            s.hs = !(m_x >= HA + HFP && m_x < HA + HFP + HS);
            s.vs = !(m_y >= VA + VFP && m_y < VA + VFP + VS);
            s.de = (m_x < HA) && (m_y < VA);
`ifdef VIDEO_TEST_PATTERN_EN
            if (s.de) s.pat = bars[m_x / (HA / 8)];
`endif
        end
        return s;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e.x   = m_x;
        e.y   = m_y;
        e.px  = m_x >> SS;
        e.py  = m_y >> SS;
        e.act = m_run && (m_x < HA) && (m_y < VA);
        e.ls  = m_run && (m_x == 0);
        e.fs  = m_run && (m_x == 0) && (m_y == 0);
        e.hs  = d2.hs;
        e.vs  = d2.vs;
        e.de  = d2.de;
        e.pat = d2.pat;
        return e;
    endfunction

    task automatic model_reset();
        m_run = 1'b0; m_x = 0; m_y = 0;
        d1 = idle_stg(); d2 = idle_stg();
    endtask

    task automatic model_edge(input bit en);
        d2 = d1;
        d1 = stage0();
        if (!m_run) begin
            if (en) m_run = 1'b1;
        end else if (m_x == HT - 1) begin
            m_x = 0;
            if (m_y == VT - 1) begin
                m_y = 0;
                if (!en) m_run = 1'b0;
            end else begin
                m_y++;
            end
        end else begin
            m_x++;
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    endtask

    task automatic tick(input bit en, input bit rn);
        @(negedge clk);
        vif.enable = en;
        rstn = rn;
        @(posedge clk);
        if (!rn) model_reset();
        else model_edge(en);
        sb.push_back(expect_now());
    endtask

    task automatic reset_mid();
        @(negedge clk);
        vif.enable = 1'b1;
        @(posedge clk);
        model_edge(1'b1);
        #1;
        chk("x_before_reset", int'(vif.x), 9);
        rstn = 1'b0;
        model_reset();
        sb.push_back(expect_now());
    endtask

    // Monitor: pops one expectation per cycle and measures start-pulse spacing.
    initial begin
        exp_t e;
        int cyc, last_fs, last_ls;
        cyc = 0; last_fs = -1; last_ls = -1;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("x", int'(vif.x), e.x);
                chk("y", int'(vif.y), e.y);
                chk("px", int'(vif.px), e.px);
                chk("py", int'(vif.py), e.py);
                chk("active", int'(vif.active), int'(e.act));
                chk("line_start", int'(vif.line_start), int'(e.ls));
                chk("frame_start", int'(vif.frame_start), int'(e.fs));
                chk("vga_hsync", int'(vif.vga_hsync), int'(e.hs));
                chk("vga_vsync", int'(vif.vga_vsync), int'(e.vs));
                chk("vga_de", int'(vif.vga_de), int'(e.de));
                chk("pat_rgb", int'(vif.pat_rgb), e.pat);
            end
            if (meas) begin
                if (vif.frame_start) begin
                    if (last_fs >= 0) fs_iv.push_back(cyc - last_fs);
                    last_fs = cyc;
                end
                if (vif.line_start) begin
                    if (last_ls >= 0) ls_iv.push_back(cyc - last_ls);
                    last_ls = cyc;
                end
            end
        end
    end

    initial begin
        vif.enable = 1'b0;
        model_reset();
        #1;
        sb.push_back(expect_now());
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);

        repeat (50) tick(1'b0, 1'b1);

        meas = 1'b1;
        repeat (3 * HT * VT) tick(1'b1, 1'b1);
        meas = 1'b0;

        for (int i = 0; i < 300 && !(m_x == 5 && m_y == 1); i++) tick(1'b1, 1'b1);
        repeat (20) tick(1'b0, 1'b1);
        repeat (HT * VT) tick(1'b1, 1'b1);

        for (int i = 0; i < 300 && !(m_x == 3 && m_y == 2); i++) tick(1'b1, 1'b1);
        repeat (HT * VT + 30) tick(1'b0, 1'b1);

        for (int i = 0; i < 300 && !(m_run && m_x == 8 && m_y == 1); i++) tick(1'b1, 1'b1);
        reset_mid();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        repeat (40) tick(1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("frame_start_count", fs_iv.size(), 2);
        foreach (fs_iv[i]) chk("frame_start_period", fs_iv[i], HT * VT);
        chk("line_start_count", ls_iv.size(), 3 * VT - 1);
        foreach (ls_iv[i]) chk("line_start_period", ls_iv[i], HT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
